// File: rtl/systolic_pe_array_pkg.sv
// Shared widths, signed types and the saturating-add helper for the systolic PE array.
// The helper is used only when PE_SUM_SATURATE_EN is defined.
package systolic_pe_array_pkg;

  localparam int unsigned ACT_W = 8;
  localparam int unsigned WGT_W = 8;
  localparam int unsigned SUM_W = 16;

  typedef logic signed [ACT_W-1:0] act_t;
  typedef logic signed [WGT_W-1:0] wgt_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  // Overflow shows up as disagreement between the two top bits of the widened sum.
  function automatic sum_t sat_add(input sum_t a, input sum_t b);
    logic signed [SUM_W:0] full;
    full = {a[SUM_W-1], a} + {b[SUM_W-1], b};
    if (full[SUM_W] != full[SUM_W-1]) begin
      return full[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
    end
    return full[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/systolic_pe_array_if.sv
// Feeder-side bus of the systolic PE array: control, edge activations/weights and results.
interface systolic_pe_array_if #(
  parameter int unsigned NUM1 = 2,
  parameter int unsigned NUM2 = 2
);
  import systolic_pe_array_pkg::*;

  logic                    EN;
  logic                    SELECTOR;
  logic                    W_EN;
  logic [NUM1*ACT_W-1:0]   active_left;
  logic [NUM2*WGT_W-1:0]   in_weight_above;
  logic [NUM2*SUM_W-1:0]   out_sum_final;
  logic [NUM2*WGT_W-1:0]   out_weight_final;

  modport master (
    output EN, SELECTOR, W_EN, active_left, in_weight_above,
    input  out_sum_final, out_weight_final
  );

  modport slave (
    input  EN, SELECTOR, W_EN, active_left, in_weight_above,
    output out_sum_final, out_weight_final
  );

endinterface

// File: rtl/systolic_pe_array_pe_cell.sv
// One weight-stationary MAC cell with double-buffered weights (WA/WB).
// Macro PE_SUM_SATURATE_EN selects a saturating accumulate instead of a wrapping one.
module systolic_pe_array_pe_cell
  import systolic_pe_array_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sel,
  input  logic w_en,
  input  act_t act_in,
  input  wgt_t wgt_in,
  input  sum_t sum_in,
  output act_t act_out,
  output wgt_t wgt_out,
  output sum_t sum_out
);

  act_t act_q;
  wgt_t wa_q, wb_q;
  sum_t sum_q;

  wgt_t w_cmp;
  sum_t prod;
  sum_t sum_d;

  // sel=1: WA loads, WB computes; sel=0: the reverse.
  always_comb begin
    w_cmp = sel ? wb_q : wa_q;
    prod  = sum_t'(act_in) * sum_t'(w_cmp);
`ifdef PE_SUM_SATURATE_EN
    sum_d = sat_add(sum_in, prod);
`else
    sum_d = sum_in + prod;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      wa_q  <= '0;
      wb_q  <= '0;
      sum_q <= '0;
    end else if (en) begin
      act_q <= act_in;
      sum_q <= sum_d;
      if (w_en) begin
        if (sel) wa_q <= wgt_in;
        else     wb_q <= wgt_in;
      end
    end
  end

  assign act_out = act_q;
  assign sum_out = sum_q;
  assign wgt_out = sel ? wa_q : wb_q;

endmodule

// File: rtl/systolic_pe_array.sv
// NUM1 x NUM2 weight-stationary systolic MAC array: activations flow right, weights and sums down.
// Optional macro PE_SUM_SATURATE_EN makes every cell accumulate with signed saturation.
module systolic_pe_array
  import systolic_pe_array_pkg::*;
#(
  parameter int unsigned NUM1 = 2,
  parameter int unsigned NUM2 = 2
) (
  input logic                 CLK,
  input logic                 RESET,
  systolic_pe_array_if.slave  bus
);

  // Column 0 / row 0 entries carry the edge inputs; the extra slot holds each cell's output.
  act_t act_h [NUM1][NUM2+1];
  wgt_t wgt_v [NUM1+1][NUM2];
  sum_t sum_v [NUM1+1][NUM2];

  for (genvar r = 0; r < NUM1; r++) begin : g_row_in
    assign act_h[r][0] = bus.active_left[r*ACT_W +: ACT_W];
  end

  for (genvar c = 0; c < NUM2; c++) begin : g_col_io
    assign wgt_v[0][c] = bus.in_weight_above[c*WGT_W +: WGT_W];
    assign sum_v[0][c] = '0;
    assign bus.out_sum_final[c*SUM_W +: SUM_W]    = sum_v[NUM1][c];
    assign bus.out_weight_final[c*WGT_W +: WGT_W] = wgt_v[NUM1][c];
  end

  for (genvar r = 0; r < NUM1; r++) begin : g_row
    for (genvar c = 0; c < NUM2; c++) begin : g_col
      systolic_pe_array_pe_cell u_pe (
        .clk     (CLK),
        .rst_n   (RESET),
        .en      (bus.EN),
        .sel     (bus.SELECTOR),
        .w_en    (bus.W_EN),
        .act_in  (act_h[r][c]),
        .wgt_in  (wgt_v[r][c]),
        .sum_in  (sum_v[r][c]),
        .act_out (act_h[r][c+1]),
        .wgt_out (wgt_v[r+1][c]),
        .sum_out (sum_v[r+1][c])
      );
    end
  end

endmodule

// File: tb/tb_systolic_pe_array.sv
// Scoreboard bench for systolic_pe_array: a dot-product reference model predicts every cycle,
// a separate monitor compares the DUT outputs against the queued predictions.
module tb_systolic_pe_array;

  localparam int NUM1 = 2;
  localparam int NUM2 = 2;
  localparam int MAXK = 4096;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  systolic_pe_array_if #(.NUM1(NUM1), .NUM2(NUM2)) bus ();

  systolic_pe_array #(.NUM1(NUM1), .NUM2(NUM2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [NUM2*16-1:0] sums;
    logic [NUM2*8-1:0]  wts;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: both weight sets per PE plus per-step history of inputs and compute weights.
  int wa [NUM1][NUM2];
  int wb [NUM1][NUM2];
  int act_hist [MAXK][NUM1];
  int wc_hist  [MAXK][NUM1][NUM2];
  int k;
  logic [NUM2*16-1:0] last_sums;

  function automatic int model_add(input int s, input int p);
    int t;
    t = s + p;
`ifdef PE_SUM_SATURATE_EN
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
`else
    t = t & 32'hFFFF;
    if (t > 32767) t = t - 65536;
`endif
    return t;
  endfunction

  function automatic int act_at(input int j, input int r);
    return (j < 1) ? 0 : act_hist[j][r];
  endfunction

  function automatic int wgt_at(input int j, input int r, input int c);
    return (j < 1) ? 0 : wc_hist[j][r][c];
  endfunction

  // Reference model: one prediction per rising edge.
  initial begin
    exp_t e;
    byte b;
    int s;
    int ja;
    int jw;
    k = 0;
    last_sums = '0;
    for (int r = 0; r < NUM1; r++)
      for (int c = 0; c < NUM2; c++) begin
        wa[r][c] = 0;
        wb[r][c] = 0;
      end
    forever begin
      @(posedge CLK);
      if (!RESET) begin
        for (int r = 0; r < NUM1; r++)
          for (int c = 0; c < NUM2; c++) begin
            wa[r][c] = 0;
            wb[r][c] = 0;
          end
        k = 0;
        last_sums = '0;
      end else if (bus.EN) begin
        if (k < MAXK - 1) k++;
        for (int r = 0; r < NUM1; r++) begin
          b = bus.active_left[r*8 +: 8];
          act_hist[k][r] = int'(b);
          for (int c = 0; c < NUM2; c++)
            wc_hist[k][r][c] = bus.SELECTOR ? wb[r][c] : wa[r][c];
        end
        if (bus.W_EN) begin
          for (int c = 0; c < NUM2; c++) begin
            for (int r = NUM1 - 1; r > 0; r--) begin
              if (bus.SELECTOR) wa[r][c] = wa[r-1][c];
              else              wb[r][c] = wb[r-1][c];
            end
            b = bus.in_weight_above[c*8 +: 8];
            if (bus.SELECTOR) wa[0][c] = int'(b);
            else              wb[0][c] = int'(b);
          end
        end
        // Column c after step k: row r's product was formed NUM1-1-r steps ago from an input c steps older.
        for (int c = 0; c < NUM2; c++) begin
          s = 0;
          for (int r = 0; r < NUM1; r++) begin
            ja = k - c - (NUM1 - 1 - r);
            jw = k - (NUM1 - 1 - r);
            s = model_add(s, act_at(ja, r) * wgt_at(jw, r, c));
          end
          last_sums[c*16 +: 16] = s[15:0];
        end
      end
      e.sums = last_sums;
      for (int c = 0; c < NUM2; c++) begin
        s = bus.SELECTOR ? wa[NUM1-1][c] : wb[NUM1-1][c];
        e.wts[c*8 +: 8] = s[7:0];
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.out_sum_final !== e.sums) begin
          n_fail++;
          $display("FAIL out_sum_final at %0t: got %h, expected %h", $time, bus.out_sum_final,
                   e.sums);
        end
        n_checks++;
        if (bus.out_weight_final !== e.wts) begin
          n_fail++;
          $display("FAIL out_weight_final at %0t: got %h, expected %h", $time,
                   bus.out_weight_final, e.wts);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic drive(input bit en, input bit sel, input bit wen,
                       input int a0, input int a1, input int w0, input int w1);
    @(negedge CLK);
    bus.EN = en;
    bus.SELECTOR = sel;
    bus.W_EN = wen;
    bus.active_left = {8'(a1), 8'(a0)};
    bus.in_weight_above = {8'(w1), 8'(w0)};
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    bus.EN = 1'b0;
    bus.SELECTOR = 1'b0;
    bus.W_EN = 1'b0;
    bus.active_left = '0;
    bus.in_weight_above = '0;
    #1 RESET = 1'b0;

    // Reset held with random activity on the inputs.
    repeat (3) begin
      @(negedge CLK);
      bus.EN = 1'b1;
      bus.SELECTOR = 1'($urandom);
      bus.W_EN = 1'b1;
      bus.active_left = 16'($urandom);
      bus.in_weight_above = 16'($urandom);
    end
    settle();
    chk("reset_sum", 32'(bus.out_sum_final), 32'h0);
    chk("reset_wgt", 32'(bus.out_weight_final), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0);

    // Load WA with {4,3} then {2,1}.
    drive(1, 1, 1, 0, 0, 3, 4);
    drive(1, 1, 1, 0, 0, 1, 2);
    settle();
    chk("wload_final", 32'(bus.out_weight_final), 32'h0403);

    // Skewed compute on WA while WB shadow-loads {6,5} then {8,7}.
    drive(1, 0, 1, 1, 0, 5, 6);
    drive(1, 0, 1, 2, 3, 7, 8);
    drive(1, 0, 0, 0, 4, 0, 0);
    settle();
    chk("wa_col0_second", 32'(bus.out_sum_final[15:0]), 32'd14);
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("wb_shadow_final", 32'(bus.out_weight_final), 32'h0605);

    // Replay on WB.
    drive(1, 1, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 2, 3, 0, 0);
    drive(1, 1, 0, 0, 4, 0, 0);
    settle();
    chk("wb_col0_second", 32'(bus.out_sum_final[15:0]), 32'd34);
    repeat (3) drive(1, 1, 0, 0, 0, 0, 0);

    // Replay with a 3-cycle freeze carrying noise on the inputs.
    drive(1, 1, 0, 1, 0, 0, 0);
    repeat (3) drive(0, 1, 1, int'($urandom_range(255)), int'($urandom_range(255)),
                     int'($urandom_range(255)), int'($urandom_range(255)));
    drive(1, 1, 0, 2, 3, 0, 0);
    drive(1, 1, 0, 0, 4, 0, 0);
    repeat (3) drive(1, 1, 0, 0, 0, 0, 0);

    // Overflow: 127 x 127 in both rows, then -128 x -128.
    drive(1, 0, 1, 0, 0, 127, 127);
    drive(1, 0, 1, 0, 0, 127, 127);
    repeat (4) drive(1, 1, 0, 127, 127, 0, 0);
    settle();
    chk("ovf_127", 32'(bus.out_sum_final), {16'd32258, 16'd32258});
    drive(1, 1, 1, 127, 127, -128, -128);
    drive(1, 1, 1, 127, 127, -128, -128);
    repeat (4) drive(1, 0, 0, -128, -128, 0, 0);
    settle();
`ifdef PE_SUM_SATURATE_EN
    chk("ovf_m128", 32'(bus.out_sum_final), {16'h7FFF, 16'h7FFF});
`else
    chk("ovf_m128", 32'(bus.out_sum_final), {16'h8000, 16'h8000});
`endif

    // Random traffic with occasional freezes, role swaps and asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      RESET = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
      bus.EN = ($urandom_range(9) != 0);
      if ($urandom_range(7) == 0) bus.SELECTOR = ~bus.SELECTOR;
      bus.W_EN = 1'($urandom);
      bus.active_left = 16'($urandom);
      bus.in_weight_above = 16'($urandom);
    end
    @(negedge CLK);
    RESET = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_pe_array.md
Name: systolic_pe_array

Overview:
- Weight-stationary systolic MAC array of NUM1 rows × NUM2 columns of processing elements (PEs).
- Activations enter from the left edge and shift right one PE per cycle. Weights are preloaded from the top and shift down. Partial sums shift down and exit at the bottom.
- Each PE has double-buffered weights, so the next weight set loads while the current set computes.
- The block is the compute core of the accelerator. An external feeder supplies row-skewed activations.

Parameters:
- NUM1, default 2: number of rows (activation lanes).
- NUM2, default 2: number of columns (weight and sum lanes).

Ports:
- CLK, input, 1: the single clock. All state updates on the rising edge.
- RESET, input, 1: asynchronous, active-low reset.
- EN, input, 1: global enable. Low freezes every register.
- SELECTOR, input, 1: weight-buffer role select.
- W_EN, input, 1: enables the weight shift chain.
- active_left, input, NUM1*8: one 8-bit activation per row. Row r occupies bits [8r+7:8r].
- in_weight_above, input, NUM2*8: one 8-bit weight per column, entering row 0. Column c occupies bits [8c+7:8c].
- out_sum_final, output, NUM2*16: registered 16-bit sum from the bottom PE of each column. Column c occupies bits [16c+15:16c].
- out_weight_final, output, NUM2*8: load-buffer weight of the bottom row, one per column, for cascading.

Behaviour:
- Reset (RESET=0, asynchronous): every activation, weight-buffer and sum register clears to 0, so out_sum_final=0 and out_weight_final=0.
- Weight buffers: each PE(r,c) holds buffers WA and WB.
  - SELECTOR=1: WA is the load buffer and WB is the compute buffer.
  - SELECTOR=0: WB is the load buffer and WA is the compute buffer.
  - The compute-buffer choice is combinational on the current SELECTOR, so it applies on the very edge SELECTOR changes.
- Weight shift: on an edge with EN=1 and W_EN=1:
  - row 0's load buffer takes in_weight_above[c];
  - row r>0's load buffer takes row r-1's load buffer;
  - compute buffers are untouched.
  - With W_EN=0, load buffers hold.
  - NUM1 shifting edges fully load a set; the first word presented ends up in the bottom row.
- Activations: on an edge with EN=1:
  - act(r,0) takes active_left[r];
  - act(r,c) takes act(r,c-1).
- Sums: on an edge with EN=1, sum(r,c) takes sum(r-1,c) + act_in(r,c) × w(r,c).
  - act_in is the activation arriving at the PE this cycle (active_left[r] for c=0).
  - w is the compute-buffer weight.
  - Row 0 uses 0 as its upstream sum.
- Arithmetic:
  - Operands are signed two's complement; the product is 16 bits.
  - The add wraps modulo 2^16 (default build).
- Latency: active_left[r] presented before edge t contributes to out_sum_final[c] after edge t+c+NUM1-1-r.
  - The feeder must delay row r by r cycles (row skew) so that one column result forms the dot product of aligned inputs.
- EN=0: all registers hold, including the weight chain regardless of W_EN. Outputs are stable.
- Simultaneous events: SELECTOR toggle, W_EN=1 and activation flow may occur on the same edge. Compute uses the newly selected buffer while the other buffer shifts.
- Reset mid-operation: all state, both weight sets included, is lost. The weights must be reloaded.

Optional Feature:
- Macro PE_SUM_SATURATE_EN.
  - Defined: each PE add saturates to the signed 16-bit range, +32767 / -32768.
  - Undefined: the add wraps modulo 2^16.
  - Products never overflow in either build.

Decomposition:
- Shared package: ACT_W=8, WGT_W=8, SUM_W=16, plus a signed sum typedef and a saturation helper function.
- One natural sub-module: pe_cell. It holds the activation register, the WA/WB buffers and the sum register, and exposes act/sum/weight pass-through outputs.
- The top level is a generate grid of NUM1×NUM2 pe_cell instances wired right/down.

Test Plan:
- Reset: hold RESET=0 with random inputs -> out_sum_final=0 and out_weight_final=0. Release and hold all inputs at 0 -> outputs remain 0.
- Weight load: SELECTOR=1, W_EN=1, EN=1, in_weight_above={4,3} (column 1, column 0) then {2,1} -> after 2 edges row0 WA=(1,2), row1 WA=(3,4), and out_weight_final shows column 0=3, column 1=4.
- Skewed compute with WA loaded: set SELECTOR=0.
  - Row0 gets 1, 2, 0 on consecutive cycles; row1 gets 0, 3, 4, 0.
  - Column 0 outputs 10 then 14; column 1 outputs 14 then 20, one cycle later.
- Shadow load: during the previous scenario drive W_EN=1 with {6,5} then {8,7} -> results unchanged, and WB ends with row0=(7,8), row1=(5,6).
  - Toggle SELECTOR=1 and replay the activations -> column 0 outputs 7·1+5·3=22 then 7·2+5·4=34.
- EN freeze: deassert EN mid-stream for 3 cycles -> all outputs constant; resume -> the same sequence appears, shifted by 3 cycles.
- Overflow: weights and activations at 127, NUM1=2, repeated -> wrapped 16-bit value 32258 per column. Then use -128·-128 in both rows -> 32768 wraps to -32768; with PE_SUM_SATURATE_EN it clamps to 32767.
